// File: rtl/shifter_if.sv
// Signal bundle for the shifter: operand, shift-amount bits, direction and the registered result.
// There is no handshake; a new operand is accepted every clock and o follows one clock later.
interface shifter_if;
    logic [7:0] a;
    logic       s0;
    logic       s1;
    logic       s2;
    logic       left_direction;
    logic [7:0] o;

    modport master (
        output a, s0, s1, s2, left_direction,
        input  o
    );

    modport slave (
        input  a, s0, s1, s2, left_direction,
        output o
    );
endinterface

// File: rtl/shifter.sv
// 8-bit logical barrel shifter: three direction-aware mux stages (1, 2, 4) feeding one
// output register. Zero fill in both directions, no rotate, synchronous active-high reset.
module shifter (
    input  logic     clk,
    input  logic     rst,
    shifter_if.slave bus
);

    logic [7:0] stage1;
    logic [7:0] stage2;
    logic [7:0] stage3;

    // Smallest weight first; the order does not change the result for logical shifts.
    always_comb begin
        stage1 = bus.a;
        if (bus.s2) begin
            stage1 = bus.left_direction ? {bus.a[6:0], 1'b0} : {1'b0, bus.a[7:1]};
        end

        stage2 = stage1;
        if (bus.s1) begin
            stage2 = bus.left_direction ? {stage1[5:0], 2'b00} : {2'b00, stage1[7:2]};
        end

        stage3 = stage2;
        if (bus.s0) begin
            stage3 = bus.left_direction ? {stage2[3:0], 4'h0} : {4'h0, stage2[7:4]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.o <= 8'h00;
        end else begin
            bus.o <= stage3;
        end
    end

endmodule

// File: tb/tb_shifter.sv
// Bench for shifter: a driver pushes expected results computed with plain arithmetic into a
// queue; an independent monitor pops and compares one clock after each sampled input.
module tb_shifter;

    logic clk;
    logic rst;

    shifter_if bus ();

    shifter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // clock/reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // scoreboard
    logic [7:0] exp_q[$];
    string      name_q[$];
    int         total = 0;
    int         bad   = 0;

    function automatic logic [7:0] ref_shift(input int a, input int n, input bit left);
        int p;
        p = 1;
        for (int i = 0; i < n; i++) p = p * 2;
        if (left) return 8'((a * p) % 256);
        else      return 8'(a / p);
    endfunction

    // driver: drive on the falling edge, record expectation, let the rising edge sample it
    task automatic drive(input string nm, input logic [7:0] a, input logic [2:0] n,
                         input bit left, input bit r);
        @(negedge clk);
        rst                = r;
        bus.a              = a;
        bus.s0             = n[2];
        bus.s1             = n[1];
        bus.s2             = n[0];
        bus.left_direction = left;
        exp_q.push_back(r ? 8'h00 : ref_shift(int'(a), int'(n), left));
        name_q.push_back(nm);
        @(posedge clk);
    endtask

    task automatic drive_exp(input string nm, input logic [7:0] a, input logic [2:0] n,
                             input bit left, input logic [7:0] want);
        logic [7:0] model;
        model = ref_shift(int'(a), int'(n), left);
        total++;
        if (model !== want) begin
            bad++;
            $display("FAIL model_%s: model=%h required=%h", nm, model, want);
        end
        drive(nm, a, n, left, 1'b0);
    endtask

    // monitor: o is valid #1 after every rising edge that sampled a driven input
    always begin
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            logic [7:0] e;
            string      nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            total++;
            if (bus.o !== e) begin
                bad++;
                $display("FAIL %s: o=%h expected=%h", nm, bus.o, e);
            end
        end
    end

    initial begin
        rst                = 1'b1;
        bus.a              = 8'h00;
        bus.s0             = 1'b0;
        bus.s1             = 1'b0;
        bus.s2             = 1'b0;
        bus.left_direction = 1'b0;

        // reset overrides a busy input
        drive("reset0", 8'hFF, 3'd5, 1'b1, 1'b1);
        drive("reset1", 8'hFF, 3'd5, 1'b1, 1'b1);
        drive("after_reset", 8'h81, 3'd1, 1'b0, 1'b0);

        drive_exp("l_4_4",    8'd4,   3'd4, 1'b1, 8'b01000000);
        drive_exp("l_6_2",    8'd6,   3'd2, 1'b1, 8'b00011000);
        drive_exp("l_9_1",    8'd9,   3'd1, 1'b1, 8'b00010010);
        drive_exp("l_253_7",  8'd253, 3'd7, 1'b1, 8'b10000000);
        drive_exp("r_15_4",   8'd15,  3'd4, 1'b0, 8'b00000000);
        drive_exp("r_f0_4",   8'hF0,  3'd4, 1'b0, 8'b00001111);
        drive_exp("r_81_7",   8'h81,  3'd7, 1'b0, 8'b00000001);
        drive_exp("zero_l",   8'd0,   3'd0, 1'b1, 8'h00);
        drive_exp("zero_r",   8'd0,   3'd0, 1'b0, 8'h00);
        drive_exp("pass_l",   8'hA5,  3'd0, 1'b1, 8'hA5);
        drive_exp("pass_r",   8'hA5,  3'd0, 1'b0, 8'hA5);
        drive_exp("toggle_l", 8'h3C,  3'd2, 1'b1, 8'hF0);
        drive_exp("toggle_r", 8'h3C,  3'd2, 1'b0, 8'h0F);

        // exhaustive sweep with reset pulses at random points
        for (int a = 0; a < 256; a++) begin
            for (int n = 0; n < 8; n++) begin
                for (int d = 0; d < 2; d++) begin
                    if ($urandom_range(0, 63) == 0)
                        drive("rst_pulse", 8'($urandom), 3'($urandom), 1'($urandom), 1'b1);
                    drive("sweep", 8'(a), 3'(n), d[0], 1'b0);
                end
            end
        end

        // random back-to-back traffic
        for (int i = 0; i < 500; i++) begin
            drive("random", 8'($urandom), 3'($urandom_range(0, 7)), 1'($urandom),
                  ($urandom_range(0, 31) == 0));
        end

        // drain the scoreboard with a bounded wait
        for (int t = 0; t < 20 && exp_q.size() > 0; t++) @(posedge clk);
        #2;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: pending=%0d expected=0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: time=%0t limit=2000000", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
